// File: rtl/isa_io_slave.sv
// ISA I/O slave: windowed address decode, write strobe, read with IOCHRDY wait
// and timeout, synchronised bus strobes.
module isa_io_slave #(
  parameter int NUM_WIN     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [16*NUM_WIN-1:0]  win_base,
  input  logic [16*NUM_WIN-1:0]  win_mask,
  input  logic [NUM_WIN-1:0]     win_en,
  input  logic [15:0]            isa_sa,
  input  logic                   isa_aen,
  input  logic                   isa_bale,
  input  logic                   isa_ior_n,
  input  logic                   isa_iow_n,
  input  logic                   isa_sbhe_n,
  input  logic [15:0]            isa_sd_in,
  output logic [15:0]            isa_sd_out,
  output logic                   isa_sd_oe,
  output logic                   isa_iochrdy_lo,
  output logic [2:0]             cyc_win,
  output logic [15:0]            cyc_addr,
  output logic                   wr_stb,
  output logic [7:0]             wr_data,
  output logic                   rd_stb,
  input  logic [7:0]             rd_data,
  input  logic                   rd_valid,
  output logic                   rd_timeout
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_ACT   = 2'd1;
  localparam logic [1:0] RD_WAIT  = 2'd2;
  localparam logic [1:0] RD_DRIVE = 2'd3;

  logic [1:0]           state;
  logic [SYNC_STAGES:0] ior_sh;
  logic [SYNC_STAGES:0] iow_sh;
  logic [SYNC_STAGES:0] bale_sh;
  logic [15:0]          addr_lat;
  logic [15:0]          sd_lat;
  logic [7:0]           cnt;
  logic [NUM_WIN-1:0]   hit;
  logic                 any_hit;
  logic [2:0]           sel;
  logic [15:0]          sel_base;
  logic                 ior_q;
  logic                 iow_q;
  logic                 ior_fall;
  logic                 ior_rise;
  logic                 iow_fall;
  logic                 iow_rise;
  logic                 bale_fall;
  logic                 timeout_hit;
  logic [7:0]           wr_byte;

  // Top bit of each shift register holds the previous synchronised value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ior_sh  <= '1;
      iow_sh  <= '1;
      bale_sh <= '0;
    end else begin
      ior_sh  <= {ior_sh[SYNC_STAGES-1:0], isa_ior_n};
      iow_sh  <= {iow_sh[SYNC_STAGES-1:0], isa_iow_n};
      bale_sh <= {bale_sh[SYNC_STAGES-1:0], isa_bale};
    end
  end

  assign ior_q     = ior_sh[SYNC_STAGES-1];
  assign iow_q     = iow_sh[SYNC_STAGES-1];
  assign ior_fall  = ior_sh[SYNC_STAGES] & ~ior_q;
  assign ior_rise  = ~ior_sh[SYNC_STAGES] & ior_q;
  assign iow_fall  = iow_sh[SYNC_STAGES] & ~iow_q;
  assign iow_rise  = ~iow_sh[SYNC_STAGES] & iow_q;
  assign bale_fall = bale_sh[SYNC_STAGES] & ~bale_sh[SYNC_STAGES-1];

  always_comb begin
    hit = '0;
    for (int n = 0; n < NUM_WIN; n++) begin
      hit[n] = win_en[n] & ~isa_aen &
               ((addr_lat & win_mask[16*n +: 16]) ==
                (win_base[16*n +: 16] & win_mask[16*n +: 16]));
    end
  end

  assign any_hit = |hit;

  // Descending scan so the lowest-index hit wins
  always_comb begin
    sel      = '0;
    sel_base = '0;
    for (int n = NUM_WIN - 1; n >= 0; n--) begin
      if (hit[n]) begin
        sel      = 3'(n);
        sel_base = win_base[16*n +: 16];
      end
    end
  end

  assign timeout_hit = (cnt + 8'd1) == 8'(MAX_WAIT);
  assign wr_byte     = (!isa_sbhe_n && addr_lat[0]) ?
                       sd_lat[15:8] : sd_lat[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_lat       <= '0;
      sd_lat         <= '0;
      cnt            <= '0;
      isa_sd_out     <= '0;
      isa_sd_oe      <= 1'b0;
      isa_iochrdy_lo <= 1'b0;
      cyc_win        <= '0;
      cyc_addr       <= '0;
      wr_stb         <= 1'b0;
      wr_data        <= '0;
      rd_stb         <= 1'b0;
      rd_timeout     <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      if (bale_fall) addr_lat <= isa_sa;
      unique case (state)
        IDLE: begin
          if (iow_fall && ior_q && any_hit) begin
            state    <= WR_ACT;
            cyc_win  <= sel;
            cyc_addr <= addr_lat - sel_base;
          end else if (ior_fall && iow_q && any_hit) begin
            state          <= RD_WAIT;
            rd_stb         <= 1'b1;
            isa_iochrdy_lo <= 1'b1;
            cnt            <= '0;
            cyc_win        <= sel;
            cyc_addr       <= addr_lat - sel_base;
          end
        end
        WR_ACT: begin
          sd_lat <= isa_sd_in;
          if (iow_rise) begin
            wr_stb  <= 1'b1;
            wr_data <= wr_byte;
            state   <= IDLE;
          end
        end
        RD_WAIT: begin
          cnt <= cnt + 8'd1;
          if (ior_rise) begin
            isa_iochrdy_lo <= 1'b0;
            state          <= IDLE;
          end else if (rd_valid) begin
            isa_sd_out     <= {rd_data, rd_data};
            isa_sd_oe      <= 1'b1;
            isa_iochrdy_lo <= 1'b0;
            state          <= RD_DRIVE;
          end else if (timeout_hit) begin
            isa_sd_out     <= 16'hFFFF;
            isa_sd_oe      <= 1'b1;
            isa_iochrdy_lo <= 1'b0;
            rd_timeout     <= 1'b1;
            state          <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (ior_rise) begin
            isa_sd_out <= '0;
            isa_sd_oe  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isa_io_slave.sv
// Bench for isa_io_slave: vector table of ISA cycles with a scoreboard,
// plus abort, both-strobe, reset and overlap corner sequences.
module tb_isa_io_slave;

  localparam int NW = 4;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [63:0]   win_base;
  logic [63:0]   win_mask;
  logic [3:0]    win_en;
  logic [15:0]   isa_sa;
  logic          isa_aen;
  logic          isa_bale;
  logic          isa_ior_n;
  logic          isa_iow_n;
  logic          isa_sbhe_n;
  logic [15:0]   isa_sd_in;
  logic [15:0]   isa_sd_out;
  logic          isa_sd_oe;
  logic          isa_iochrdy_lo;
  logic [2:0]    cyc_win;
  logic [15:0]   cyc_addr;
  logic          wr_stb;
  logic [7:0]    wr_data;
  logic          rd_stb;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_timeout;

  isa_io_slave #(.NUM_WIN(NW), .SYNC_STAGES(2), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .win_base(win_base), .win_mask(win_mask), .win_en(win_en),
    .isa_sa(isa_sa), .isa_aen(isa_aen), .isa_bale(isa_bale),
    .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
    .isa_sbhe_n(isa_sbhe_n), .isa_sd_in(isa_sd_in),
    .isa_sd_out(isa_sd_out), .isa_sd_oe(isa_sd_oe),
    .isa_iochrdy_lo(isa_iochrdy_lo),
    .cyc_win(cyc_win), .cyc_addr(cyc_addr),
    .wr_stb(wr_stb), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        aen;
    logic        sbhe_n;
    logic        is_rd;
    logic        hit;
    logic [15:0] sd;
    int          dly;
    logic [2:0]  win;
    logic [15:0] caddr;
    logic [7:0]  data;
    int          wt;
    logic        to;
  } vec_t;

  typedef struct {
    logic [2:0]  win;
    logic [15:0] caddr;
    logic [7:0]  data;
    int          wt;
    logic        to;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   oe_cnt = 0;
  int   run = 0;
  int   last_wait = 0;
  logic prev_oe = 1'b0;
  logic prev_rdy = 1'b0;
  logic to_model = 1'b0;
  exp_t wq[$];
  exp_t rq[$];
  exp_t me;
  vec_t tbl[12];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor, sampled 1ns after each rising edge
  always @(posedge clk) begin
    #1;
    if (wr_stb) begin
      wr_cnt++;
      if (wq.size() == 0) chk("unexpected wr_stb", 1, 0);
      else begin
        me = wq.pop_front();
        chk("wr cyc_win", 32'(cyc_win), 32'(me.win));
        chk("wr cyc_addr", 32'(cyc_addr), 32'(me.caddr));
        chk("wr_data", 32'(wr_data), 32'(me.data));
      end
    end
    if (rd_stb) rd_cnt++;
    if (isa_iochrdy_lo) run++;
    else begin
      if (prev_rdy) last_wait = run;
      run = 0;
    end
    if (isa_sd_oe && !prev_oe) begin
      oe_cnt++;
      if (rq.size() == 0) chk("unexpected sd_oe", 1, 0);
      else begin
        me = rq.pop_front();
        chk("rd sd_out", 32'(isa_sd_out), 32'({me.data, me.data}));
        chk("rd cyc_win", 32'(cyc_win), 32'(me.win));
        chk("rd cyc_addr", 32'(cyc_addr), 32'(me.caddr));
        chk("rd wait cycles", 32'(last_wait), 32'(me.wt));
        chk("rd_timeout", 32'(rd_timeout), 32'(me.to));
      end
    end
    prev_oe  = isa_sd_oe;
    prev_rdy = isa_iochrdy_lo;
  end

  task automatic latch_addr(logic [15:0] a, logic aen, logic sbhe_n);
    @(negedge clk);
    isa_sa     = a;
    isa_aen    = aen;
    isa_sbhe_n = sbhe_n;
    isa_bale   = 1'b1;
    repeat (2) @(negedge clk);
    isa_bale = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rd_stb(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_stb) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_oe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (isa_sd_oe) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_valid(logic [7:0] d);
    rd_valid = 1'b1;
    rd_data  = d;
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic run_vec(vec_t v, int idx);
    int   w0, r0, o0;
    bit   seen;
    exp_t e;
    latch_addr(v.addr, v.aen, v.sbhe_n);
    w0 = wr_cnt;
    r0 = rd_cnt;
    o0 = oe_cnt;
    e.win   = v.win;
    e.caddr = v.caddr;
    e.data  = v.data;
    e.wt    = v.wt;
    if (v.is_rd && v.hit && v.to) to_model = 1'b1;
    e.to = to_model;
    if (!v.is_rd) begin
      isa_sd_in = v.sd;
      if (v.hit) wq.push_back(e);
      isa_iow_n = 1'b0;
      repeat (4) @(negedge clk);
      isa_iow_n = 1'b1;
      repeat (5) @(negedge clk);
    end else begin
      if (v.hit) rq.push_back(e);
      isa_ior_n = 1'b0;
      if (v.hit) begin
        wait_rd_stb(seen);
        chk($sformatf("v%0d rd_stb seen", idx), 32'(seen), 1);
        if (v.dly != 255) begin
          repeat (v.dly) @(negedge clk);
          pulse_valid(v.data);
        end
        wait_oe(seen);
        chk($sformatf("v%0d sd_oe seen", idx), 32'(seen), 1);
        repeat (2) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      isa_ior_n = 1'b1;
      repeat (5) @(negedge clk);
    end
    chk($sformatf("v%0d wr_stb count", idx), 32'(wr_cnt - w0),
        32'(v.hit && !v.is_rd));
    chk($sformatf("v%0d rd_stb count", idx), 32'(rd_cnt - r0),
        32'(v.hit && v.is_rd));
    chk($sformatf("v%0d sd_oe count", idx), 32'(oe_cnt - o0),
        32'(v.hit && v.is_rd));
    chk($sformatf("v%0d sd_oe released", idx), 32'(isa_sd_oe), 0);
  endtask

  initial begin
    int  w0, r0, o0;
    bit  seen;
    exp_t e;
    // addr aen sbhe rd hit sd dly win caddr data wait to
    tbl[0]  = '{16'h022C, 0, 1, 0, 1, 16'h00A5, 0, 0, 16'h000C, 8'hA5, 0, 0};
    tbl[1]  = '{16'h0389, 0, 0, 0, 1, 16'h5A00, 0, 1, 16'h0001, 8'h5A, 0, 0};
    tbl[2]  = '{16'h0330, 0, 1, 1, 1, 16'h0000, 3, 3, 16'h0000, 8'h3C, 4, 0};
    tbl[3]  = '{16'h022C, 1, 1, 0, 0, 16'h00EE, 0, 0, 16'h0000, 8'h00, 0, 0};
    tbl[4]  = '{16'h0300, 0, 1, 0, 0, 16'h00EE, 0, 0, 16'h0000, 8'h00, 0, 0};
    tbl[5]  = '{16'h0300, 0, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0};
    tbl[6]  = '{16'h02F0, 0, 1, 0, 1, 16'h1234, 0, 2, 16'h00D0, 8'h34, 0, 0};
    tbl[7]  = '{16'h0389, 0, 1, 0, 1, 16'h5A77, 0, 1, 16'h0001, 8'h77, 0, 0};
    tbl[8]  = '{16'h0388, 0, 0, 0, 1, 16'hBB11, 0, 1, 16'h0000, 8'h11, 0, 0};
    tbl[9]  = '{16'h0221, 0, 1, 1, 1, 16'h0000, 0, 0, 16'h0001, 8'h81, 1, 0};
    tbl[10] = '{16'h038A, 0, 1, 1, 1, 16'h0000, 14, 1, 16'h0002, 8'h42, 15, 0};
    tbl[11] = '{16'h0331, 0, 1, 1, 1, 16'h0000, 255, 3, 16'h0001, 8'hFF, 15, 1};

    win_base   = {16'h0330, 16'h0220, 16'h0388, 16'h0220};
    win_mask   = {16'hFFF0, 16'hFF00, 16'hFFFC, 16'hFFF0};
    win_en     = 4'hF;
    rst_n      = 1'b0;
    isa_sa     = '0;
    isa_aen    = 1'b0;
    isa_bale   = 1'b0;
    isa_ior_n  = 1'b1;
    isa_iow_n  = 1'b1;
    isa_sbhe_n = 1'b1;
    isa_sd_in  = '0;
    rd_data    = '0;
    rd_valid   = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset sd_out", 32'(isa_sd_out), 0);
    chk("reset sd_oe", 32'(isa_sd_oe), 0);
    chk("reset iochrdy_lo", 32'(isa_iochrdy_lo), 0);
    chk("reset strobes", 32'({wr_stb, rd_stb}), 0);
    chk("reset cyc_win", 32'(cyc_win), 0);
    chk("reset cyc_addr", 32'(cyc_addr), 0);
    chk("reset wr_data", 32'(wr_data), 0);
    chk("reset rd_timeout", 32'(rd_timeout), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // Abort: IOR rises during the wait, later rd_valid must be ignored
    latch_addr(16'h0330, 1'b0, 1'b1);
    r0 = rd_cnt;
    o0 = oe_cnt;
    isa_ior_n = 1'b0;
    wait_rd_stb(seen);
    chk("abort rd_stb seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
    isa_ior_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort iochrdy released", 32'(isa_iochrdy_lo), 0);
    pulse_valid(8'h99);
    repeat (5) @(negedge clk);
    chk("abort no sd_oe", 32'(oe_cnt - o0), 0);
    chk("abort rd_stb count", 32'(rd_cnt - r0), 1);

    // Both strobes low together: ignored
    latch_addr(16'h022C, 1'b0, 1'b1);
    w0 = wr_cnt;
    r0 = rd_cnt;
    o0 = oe_cnt;
    isa_sd_in = 16'h00C7;
    isa_iow_n = 1'b0;
    isa_ior_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("both-low iochrdy", 32'(isa_iochrdy_lo), 0);
    isa_iow_n = 1'b1;
    isa_ior_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("both-low no wr_stb", 32'(wr_cnt - w0), 0);
    chk("both-low no rd_stb", 32'(rd_cnt - r0), 0);
    chk("both-low no sd_oe", 32'(oe_cnt - o0), 0);

    // Reset during RD_DRIVE releases the bus at the next edge
    latch_addr(16'h0330, 1'b0, 1'b1);
    e.win   = 3'd3;
    e.caddr = 16'h0000;
    e.data  = 8'hC3;
    e.wt    = 1;
    e.to    = to_model;
    rq.push_back(e);
    isa_ior_n = 1'b0;
    wait_rd_stb(seen);
    chk("rst-drive rd_stb seen", 32'(seen), 1);
    pulse_valid(8'hC3);
    wait_oe(seen);
    chk("rst-drive sd_oe seen", 32'(seen), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst-drive sd_oe", 32'(isa_sd_oe), 0);
    chk("rst-drive sd_out", 32'(isa_sd_out), 0);
    chk("rst-drive rd_timeout", 32'(rd_timeout), 0);
    @(negedge clk);
    isa_ior_n = 1'b1;
    to_model  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("write queue drained", 32'(wq.size()), 0);
    chk("read queue drained", 32'(rq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
